// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: funct3 op codes,
// FSM states and small op-classification helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_is_rem(input md_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic op_a_signed(input md_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(input md_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit_iter_step.sv
// One iteration of the shared datapath: shift-add multiply step or restoring
// trial-subtract divide step on a single 2*XLEN accumulator.
module muldiv_iter_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                div_mode,
  input  logic [2*XLEN-1:0]   acc_i,
  input  logic [XLEN-1:0]     opnd_i,
  output logic [2*XLEN-1:0]   acc_o
);

  logic [XLEN:0] addend;
  logic [XLEN:0] add_sum;
  logic [XLEN:0] trial;
  logic [XLEN:0] sub_diff;

  // Multiply: {hi, multiplier} shifts right, carry lands in the top bit.
  // Divide: {rem, dividend} shifts left, the freed LSB takes the quotient bit.
  always_comb begin
    addend   = acc_i[0] ? {1'b0, opnd_i} : '0;
    add_sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + addend;
    trial    = acc_i[2*XLEN-1:XLEN-1];
    sub_diff = trial - {1'b0, opnd_i};
    if (div_mode) begin
      if (sub_diff[XLEN]) begin
        acc_o = {trial[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end else begin
        acc_o = {sub_diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_o = {add_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one bit per cycle, valid/ready
// handshake, tag pass-through, flush, and RISC-V divide corner cases.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  md_op_e            op_q, op_d;
  logic              neg_q, neg_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [XLEN-1:0]   out_result_q, out_result_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;

  md_op_e          in_op_e;
  logic            a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b;

  function automatic logic [XLEN-1:0] post_proc(input md_op_e op, input logic neg,
                                                input logic [2*XLEN-1:0] acc);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   res;
    prod = neg ? -acc : acc;
    quot = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      OP_MUL:                       res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              res = quot;
      default:                      res = rem;
    endcase
    return res;
  endfunction

  assign in_op_e  = md_op_e'(in_op);
  assign a_neg    = op_a_signed(in_op_e) & in_a[XLEN-1];
  assign b_neg    = op_b_signed(in_op_e) & in_b[XLEN-1];
  assign abs_a    = a_neg ? -in_a : in_a;
  assign abs_b    = b_neg ? -in_b : in_b;
  assign div_zero = op_is_div(in_op_e) && (in_b == '0);
  assign div_ovf  = (in_op_e inside {OP_DIV, OP_REM}) && (in_a == MIN_NEG) && (in_b == '1);

  muldiv_iter_step #(.XLEN(XLEN)) u_step (
    .div_mode (op_is_div(op_q)),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_step)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    opnd_d       = opnd_q;
    op_d         = op_q;
    neg_d        = neg_q;
    tag_d        = tag_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          op_d   = in_op_e;
          tag_d  = in_tag;
          acc_d  = {{XLEN{1'b0}}, abs_a};
          opnd_d = abs_b;
          cnt_d  = CNT_LAST;
          // The remainder follows the dividend's sign; everything else the XOR.
          neg_d  = op_is_rem(in_op_e) ? a_neg : (a_neg ^ b_neg);
          if (div_zero) begin
            out_result_d = op_is_rem(in_op_e) ? in_a : '1;
            out_tag_d    = in_tag;
            state_d      = ST_DONE;
          end else if (div_ovf) begin
            out_result_d = op_is_rem(in_op_e) ? '0 : in_a;
            out_tag_d    = in_tag;
            state_d      = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          out_result_d = post_proc(op_q, neg_q, acc_step);
          out_tag_d    = tag_q;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
    acc_q  <= acc_d;
    opnd_q <= opnd_d;
    op_q   <= op_d;
    neg_q  <= neg_d;
    tag_q  <= tag_d;
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus randomized bench for muldiv_unit at XLEN=32 and XLEN=64,
// checked against a plain-arithmetic RISC-V M-extension reference model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, sel64, drv_valid, drv_oready;
  logic [2:0]  drv_op;
  logic [63:0] drv_a, drv_b;
  logic [4:0]  drv_tag;

  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  logic [31:0] out_result32;
  logic [63:0] out_result64;
  logic [4:0]  out_tag32, out_tag64;

  logic        obs_ready, obs_valid;
  logic [63:0] obs_result;
  logic [4:0]  obs_tag;

  int tests = 0;
  int fails = 0;

  muldiv_unit #(.XLEN(32), .TAG_W(5)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(drv_valid & ~sel64), .in_ready(in_ready32), .in_op(drv_op),
    .in_a(drv_a[31:0]), .in_b(drv_b[31:0]), .in_tag(drv_tag),
    .out_valid(out_valid32), .out_ready(drv_oready & ~sel64),
    .out_result(out_result32), .out_tag(out_tag32)
  );

  muldiv_unit #(.XLEN(64), .TAG_W(5)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(drv_valid & sel64), .in_ready(in_ready64), .in_op(drv_op),
    .in_a(drv_a), .in_b(drv_b), .in_tag(drv_tag),
    .out_valid(out_valid64), .out_ready(drv_oready & sel64),
    .out_result(out_result64), .out_tag(out_tag64)
  );

  assign obs_ready  = sel64 ? in_ready64 : in_ready32;
  assign obs_valid  = sel64 ? out_valid64 : out_valid32;
  assign obs_result = sel64 ? out_result64 : {32'd0, out_result32};
  assign obs_tag    = sel64 ? out_tag64 : out_tag32;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [63:0] mask_of(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] min_of(input int w);
    return (w == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
  endfunction

  function automatic bit is_special(input int w, input logic [2:0] op,
                                    input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] a, b;
    a = a_in & mask_of(w);
    b = b_in & mask_of(w);
    if (!op[2]) return 1'b0;
    if (b == 64'd0) return 1'b1;
    return (op == 3'd4 || op == 3'd6) && a == min_of(w) && b == mask_of(w);
  endfunction

  function automatic logic [63:0] ref_model(input int w, input logic [2:0] op,
                                            input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] mask, a, b, res;
    logic signed [129:0] sa, sb, p, q, r;
    logic a_sgn, b_sgn;
    mask  = mask_of(w);
    a     = a_in & mask;
    b     = b_in & mask;
    a_sgn = op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
    b_sgn = op inside {3'd0, 3'd1, 3'd4, 3'd6};
    sa = $signed({66'd0, a});
    sb = $signed({66'd0, b});
    if (a_sgn && (a & min_of(w)) != 64'd0) sa = sa - (130'sd1 <<< w);
    if (b_sgn && (b & min_of(w)) != 64'd0) sb = sb - (130'sd1 <<< w);
    if (!op[2]) begin
      p = sa * sb;
      if (op == 3'd0)   res = p[63:0];
      else if (w == 64) res = p[127:64];
      else              res = {32'd0, p[63:32]};
    end else if (b == 64'd0) begin
      res = op[1] ? a : mask;
    end else if (a_sgn && a == min_of(w) && b == mask) begin
      res = op[1] ? 64'd0 : a;
    end else begin
      q = sa / sb;
      r = sa % sb;
      res = op[1] ? r[63:0] : q[63:0];
    end
    return res & mask;
  endfunction

  function automatic logic [63:0] rand_operand(input int w);
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return mask_of(w);
      2:       return min_of(w);
      3:       return 64'($urandom_range(0, 15));
      default: return {$urandom, $urandom} & mask_of(w);
    endcase
  endfunction

  task automatic issue(input int w, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag);
    int k;
    sel64 = (w == 64);
    k = 0;
    @(negedge clk);
    while (obs_ready !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("idle_wait", 64'(obs_ready), 64'd1);
    drv_op    = op;
    drv_a     = a;
    drv_b     = b;
    drv_tag   = tag;
    drv_valid = 1'b1;
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    drv_op    = 3'($urandom);
    drv_a     = {$urandom, $urandom};
    drv_b     = {$urandom, $urandom};
    drv_tag   = 5'($urandom);
  endtask

  task automatic run_op(input int w, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] tag,
                        input logic [63:0] exp, input int hold, input string name);
    int c, exp_lat;
    exp_lat = is_special(w, op, a, b) ? 1 : w + 1;
    issue(w, op, a, b, tag);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (obs_valid !== 1'b1 && c < 200);
    check({name, "_lat"}, 64'(c), 64'(exp_lat));
    check({name, "_res"}, obs_result, exp);
    check({name, "_tag"}, 64'(obs_tag), 64'(tag));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({name, "_bp_valid"}, 64'(obs_valid), 64'd1);
      check({name, "_bp_res"}, obs_result, exp);
      check({name, "_bp_tag"}, 64'(obs_tag), 64'(tag));
      check({name, "_bp_inrdy"}, 64'(obs_ready), 64'd0);
    end
    drv_oready = 1'b1;
    @(posedge clk);
    #1;
    drv_oready = 1'b0;
    check({name, "_ack_valid"}, 64'(obs_valid), 64'd0);
    check({name, "_ack_inrdy"}, 64'(obs_ready), 64'd1);
  endtask

  task automatic expect_silence(input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (obs_valid === 1'b1) seen++;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [63:0] a, b;
    logic [4:0]  tag;

    rst = 1'b1; flush = 1'b0; sel64 = 1'b0; drv_valid = 1'b0; drv_oready = 1'b0;
    drv_op = 3'd0; drv_a = 64'd0; drv_b = 64'd0; drv_tag = 5'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid32", 64'(out_valid32), 64'd0);
    check("rst_res32",   64'(out_result32), 64'd0);
    check("rst_tag32",   64'(out_tag32), 64'd0);
    check("rst_inrdy32", 64'(in_ready32), 64'd1);
    check("rst_valid64", 64'(out_valid64), 64'd0);
    check("rst_res64",   out_result64, 64'd0);
    check("rst_inrdy64", 64'(in_ready64), 64'd1);

    run_op(32, 3'd0, 64'h7,          64'hFFFF_FFFD, 5'd12, 64'hFFFF_FFEB, 0, "mul");
    run_op(32, 3'd1, 64'h8000_0000,  64'h8000_0000, 5'd1,  64'h4000_0000, 0, "mulh");
    run_op(32, 3'd3, 64'hFFFF_FFFF,  64'hFFFF_FFFF, 5'd2,  64'hFFFF_FFFE, 0, "mulhu");
    run_op(32, 3'd2, 64'hFFFF_FFFF,  64'hFFFF_FFFF, 5'd3,  64'hFFFF_FFFF, 0, "mulhsu");
    run_op(32, 3'd4, 64'hFFFF_FFF9,  64'h2,         5'd4,  64'hFFFF_FFFD, 0, "div");
    run_op(32, 3'd6, 64'hFFFF_FFF9,  64'h2,         5'd5,  64'hFFFF_FFFF, 0, "rem");
    run_op(32, 3'd5, 64'd100,        64'd7,         5'd6,  64'd14,        0, "divu");
    run_op(32, 3'd7, 64'd100,        64'd7,         5'd7,  64'd2,         0, "remu");
    run_op(32, 3'd0, 64'h1234_5678,  64'd0,         5'd8,  64'd0,         0, "mul_b0");
    run_op(32, 3'd4, 64'd5,          64'd0,         5'd9,  64'hFFFF_FFFF, 0, "div_by0");
    run_op(32, 3'd7, 64'd5,          64'd0,         5'd10, 64'd5,         0, "remu_by0");
    run_op(32, 3'd4, 64'h8000_0000,  64'hFFFF_FFFF, 5'd11, 64'h8000_0000, 0, "div_ovf");
    run_op(32, 3'd6, 64'h8000_0000,  64'hFFFF_FFFF, 5'd13, 64'd0,         0, "rem_ovf");
    run_op(32, 3'd3, 64'hDEAD_BEEF,  64'h1234_5678, 5'd21,
           ref_model(32, 3'd3, 64'hDEAD_BEEF, 64'h1234_5678), 6, "backpressure");

    // Flush in the tenth CALC cycle drops the op.
    issue(32, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd14);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_valid", 64'(obs_valid), 64'd0);
    check("flush_inrdy", 64'(obs_ready), 64'd1);
    expect_silence("flush_silent");
    run_op(32, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd15, 64'hFFFF_FFFE, 0, "post_flush");

    // Flush together with a request in IDLE: request is ignored.
    @(negedge clk);
    drv_op = 3'd0; drv_a = 64'd3; drv_b = 64'd3; drv_tag = 5'd16;
    drv_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 drv_valid = 1'b0; flush = 1'b0;
    check("flush_req_inrdy", 64'(obs_ready), 64'd1);
    expect_silence("flush_req_silent");

    // Reset pulse mid-CALC.
    issue(32, 3'd5, 64'd1000, 64'd3, 5'd17);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_valid", 64'(obs_valid), 64'd0);
    check("midrst_res",   obs_result, 64'd0);
    check("midrst_tag",   64'(obs_tag), 64'd0);
    check("midrst_inrdy", 64'(obs_ready), 64'd1);
    expect_silence("midrst_silent");
    run_op(32, 3'd3, 64'h8000_0001, 64'h0000_0003, 5'd18, 64'h1, 0, "post_rst");

    run_op(64, 3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd19,
           64'h4000_0000_0000_0000, 0, "mulh64");
    run_op(64, 3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd20,
           64'hFFFF_FFFF_FFFF_FFFF, 0, "rem64");

    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom);
      a   = rand_operand(32);
      b   = rand_operand(32);
      tag = 5'($urandom);
      run_op(32, op, a, b, tag, ref_model(32, op, a, b), 0, "rnd32");
    end
    for (int i = 0; i < 20; i++) begin
      op  = 3'($urandom);
      a   = rand_operand(64);
      b   = rand_operand(64);
      tag = 5'($urandom);
      run_op(64, op, a, b, tag, ref_model(64, op, a, b), 0, "rnd64");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
